// File: rtl/result_mem_uart_tx.sv
`default_nettype none
// ============================================================================
// result_mem_uart_tx : result memory plus 8N1 UART dump, high byte first
// Revision 1.0
// ============================================================================
module result_mem_uart_tx #(
  parameter int ROWS         = 2,
  parameter int COLS         = 2,
  parameter int DATA_W       = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_R,
  input  logic [5:0]        write_address,
  input  logic [DATA_W-1:0] write_value,
  input  logic              start_tx,
  output logic              tx_data,
  output logic              busy,
  output logic              done
);

  localparam int N  = ROWS * COLS;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [AW-1:0] C_LAST_ELEM = AW'(N - 1);
  localparam logic [CW-1:0] C_BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [6:0]    C_N_ADDR    = 7'(N);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [DATA_W-1:0] mem_q [N];
  logic [2:0]    state_q, state_d;
  logic [AW-1:0] elem_q, elem_d;
  logic          byte_hi_q, byte_hi_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          wr_en_w;
  logic          baud_tick_w;
  logic [DATA_W-1:0] rd_w;

  // Writes are locked out for the whole dump so the stream is a consistent snapshot.
  assign wr_en_w     = write_R && !busy_q && ({1'b0, write_address} < C_N_ADDR);
  assign baud_tick_w = (baud_q == C_BAUD_LAST);
  assign rd_w        = mem_q[elem_q];

  always_ff @(posedge clk) begin
    if (wr_en_w) begin
      mem_q[write_address[AW-1:0]] <= write_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      elem_q    <= '0;
      byte_hi_q <= 1'b1;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      elem_q    <= elem_d;
      byte_hi_q <= byte_hi_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    byte_hi_d = byte_hi_q;
    baud_d    = '0;
    bit_d     = bit_q;
    shift_d   = shift_q;
    case (state_q)
      S_IDLE: begin
        if (start_tx) begin
          elem_d    = '0;
          byte_hi_d = 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        shift_d = byte_hi_q ? rd_w[15:8] : rd_w[7:0];
        bit_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        baud_d = baud_q + 1'b1;
        if (baud_tick_w) begin
          baud_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        baud_d = baud_q + 1'b1;
        if (baud_tick_w) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        baud_d = baud_q + 1'b1;
        if (baud_tick_w) begin
          baud_d = '0;
          if (byte_hi_q) begin
            byte_hi_d = 1'b0;
            state_d   = S_LOAD;
          end else if (elem_q == C_LAST_ELEM) begin
            state_d = S_DONE;
          end else begin
            elem_d    = elem_q + 1'b1;
            byte_hi_d = 1'b1;
            state_d   = S_LOAD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Line level is registered from the current state, so it trails the state by one cycle.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = busy_q;
    done_d = done_q;
    case (state_q)
      S_IDLE: begin
        if (start_tx) begin
          busy_d = 1'b1;
          done_d = 1'b0;
        end
      end
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_q[0];
      S_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_data = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_result_mem_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_result_mem_uart_tx : cycle-level reference of the dump waveform plus UART decoder
// Revision 1.0
// ============================================================================
module tb_result_mem_uart_tx;

  localparam int CPB     = 4;
  localparam int NEL     = 4;
  localparam int BYTE_CY = 10 * CPB + 1;
  localparam int BUSY_CY = NEL * 2 * BYTE_CY + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write_R = 1'b0;
  logic [5:0]  write_address = '0;
  logic [15:0] write_value = '0;
  logic        start_tx = 1'b0;
  logic        tx_data, busy, done;

  int tests = 0;
  int fails = 0;

  result_mem_uart_tx #(.ROWS(2), .COLS(2), .DATA_W(16), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .write_R(write_R), .write_address(write_address),
    .write_value(write_value), .start_tx(start_tx), .tx_data(tx_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference: memory image, byte list of the dump in flight, cycle index since start edge
  logic [15:0] m_mem [NEL];
  logic [7:0]  m_bytes [2*NEL];
  bit          m_active = 1'b0;
  bit          m_done = 1'b0;
  int          m_c = 0;

  function automatic logic exp_tx();
    int p, b, r;
    if (!m_active || m_c < 2) return 1'b1;
    p = m_c - 2;
    b = p / BYTE_CY;
    r = p % BYTE_CY;
    if (r < CPB) return 1'b0;
    if (r < 9 * CPB) return m_bytes[b][(r - CPB) / CPB];
    return 1'b1;
  endfunction

  always begin
    @(posedge clk);
    if (!rst_n) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_c      = 0;
    end else if (m_active) begin
      m_c++;
      if (m_c == BUSY_CY) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end else begin
      if (write_R && write_address < 6'(NEL)) m_mem[write_address[1:0]] = write_value;
      if (start_tx) begin
        for (int e = 0; e < NEL; e++) begin
          m_bytes[2*e]   = m_mem[e][15:8];
          m_bytes[2*e+1] = m_mem[e][7:0];
        end
        m_active = 1'b1;
        m_done   = 1'b0;
        m_c      = 0;
      end
    end
    #1;
    tests += 3;
    if (tx_data !== exp_tx()) begin
      fails++;
      $display("FAIL tx_cycle t=%0t c=%0d: got %b, expected %b", $time, m_c, tx_data, exp_tx());
    end
    if (busy !== m_active) begin
      fails++;
      $display("FAIL busy_cycle t=%0t c=%0d: got %b, expected %b", $time, m_c, busy, m_active);
    end
    if (done !== m_done) begin
      fails++;
      $display("FAIL done_cycle t=%0t: got %b, expected %b", $time, done, m_done);
    end
  end

  // UART decoder: mid-bit sampling, frames cut by reset are discarded
  logic [7:0] rx_q [$];
  initial begin
    logic [7:0] bv;
    logic       stopb;
    bit         aborted;
    forever begin
      @(posedge clk); #2;
      if (rst_n && tx_data === 1'b0) begin
        aborted = 1'b0;
        bv = '0;
        repeat (CPB / 2) begin @(posedge clk); #2; if (!rst_n) aborted = 1'b1; end
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) begin @(posedge clk); #2; if (!rst_n) aborted = 1'b1; end
          bv[i] = tx_data;
        end
        repeat (CPB) begin @(posedge clk); #2; if (!rst_n) aborted = 1'b1; end
        stopb = tx_data;
        if (!aborted) begin
          tests++;
          if (stopb !== 1'b1) begin
            fails++;
            $display("FAIL stop_bit: got %b, expected 1", stopb);
          end
          rx_q.push_back(bv);
        end
      end
    end
  end

  task automatic pulse(input logic wr, input logic [5:0] a, input logic [15:0] v, input logic st);
    @(negedge clk);
    write_R = wr; write_address = a; write_value = v; start_tx = st;
    @(negedge clk);
    write_R = 1'b0; start_tx = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (cycles < 4 * BUSY_CY) begin
      @(posedge clk); #1;
      cycles++;
      if (!busy) break;
    end
    tests++;
    if (busy) begin
      fails++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles, expected 0", busy, cycles);
    end
  endtask

  task automatic dump(input logic wr, input logic [5:0] a, input logic [15:0] v);
    int cy;
    rx_q.delete();
    pulse(wr, a, v, 1'b1);
    wait_idle(cy);
    repeat (3) @(posedge clk);
  endtask

  task automatic check_dump(input string name, input logic [63:0] exp);
    tests++;
    if (rx_q.size() != 8) begin
      fails++;
      $display("FAIL %s_count: got %0d bytes, expected 8", name, rx_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        tests++;
        if (rx_q[k] !== exp[63-8*k -: 8]) begin
          fails++;
          $display("FAIL %s_byte%0d: got %02h, expected %02h", name, k, rx_q[k], exp[63-8*k -: 8]);
        end
      end
    end
  endtask

  initial begin
    int cy;
    int hi;
    for (int e = 0; e < NEL; e++) m_mem[e] = 'x;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (tx_data !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got tx=%b busy=%b done=%b, expected 1 0 0", tx_data, busy, done);
    end
    @(negedge clk); rst_n = 1'b1;
    hi = 0;
    repeat (100) begin @(posedge clk); #1; if (tx_data === 1'b1) hi++; end
    tests++;
    if (hi != 100) begin
      fails++;
      $display("FAIL idle_line: got %0d high cycles, expected 100", hi);
    end

    pulse(1'b1, 6'd0, 16'h1234, 1'b0);
    pulse(1'b1, 6'd1, 16'h00FF, 1'b0);
    pulse(1'b1, 6'd2, 16'hABCD, 1'b0);
    pulse(1'b1, 6'd3, 16'h0001, 1'b0);
    rx_q.delete();
    pulse(1'b0, 6'd0, 16'h0, 1'b1);
    wait_idle(cy);
    tests += 2;
    if (cy != 329) begin
      fails++;
      $display("FAIL busy_length: got %0d cycles, expected 329", cy);
    end
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL done_sticky: got %b, expected 1", done);
    end
    repeat (3) @(posedge clk);
    check_dump("basic", 64'h1234_00FF_ABCD_0001);

    rx_q.delete();
    pulse(1'b0, 6'd0, 16'h0, 1'b1);
    repeat (60) @(posedge clk);
    pulse(1'b1, 6'd0, 16'hFFFF, 1'b1);
    repeat (30) @(posedge clk);
    pulse(1'b0, 6'd0, 16'h0, 1'b1);
    wait_idle(cy);
    repeat (3) @(posedge clk);
    check_dump("busy_ignore", 64'h1234_00FF_ABCD_0001);
    dump(1'b0, 6'd0, 16'h0);
    check_dump("after_busy", 64'h1234_00FF_ABCD_0001);

    pulse(1'b1, 6'd7, 16'hDEAD, 1'b0);
    dump(1'b0, 6'd0, 16'h0);
    check_dump("oob_write", 64'h1234_00FF_ABCD_0001);

    dump(1'b1, 6'd3, 16'h5A5A);
    check_dump("same_cycle", 64'h1234_00FF_ABCD_5A5A);

    rx_q.delete();
    pulse(1'b0, 6'd0, 16'h0, 1'b1);
    repeat (94) @(posedge clk);
    #1;
    tests++;
    if (tx_data !== 1'b0) begin
      fails++;
      $display("FAIL pre_reset_line: got %b, expected 0", tx_data);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (tx_data !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got tx=%b busy=%b done=%b, expected 1 0 0", tx_data, busy, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    dump(1'b0, 6'd0, 16'h0);
    check_dump("post_reset", 64'h1234_00FF_ABCD_5A5A);

    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(1, 5))
        pulse(1'b1, 6'($urandom_range(0, 7)), 16'($urandom), 1'b0);
      rx_q.delete();
      pulse(1'($urandom_range(0, 1)), 6'($urandom_range(0, 5)), 16'($urandom), 1'b1);
      repeat (5) begin
        repeat ($urandom_range(0, 40)) @(negedge clk);
        pulse(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 16'($urandom),
              1'($urandom_range(0, 1)));
      end
      wait_idle(cy);
      repeat (3) @(posedge clk);
      tests++;
      if (rx_q.size() != 8) begin
        fails++;
        $display("FAIL rand_count%0d: got %0d bytes, expected 8", r, rx_q.size());
      end else begin
        for (int k = 0; k < 8; k++) begin
          tests++;
          if (rx_q[k] !== m_bytes[k]) begin
            fails++;
            $display("FAIL rand%0d_byte%0d: got %02h, expected %02h", r, k, rx_q[k], m_bytes[k]);
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
